// File: rtl/pipe_pkg.sv
// Shared definitions for the five-stage pipeline: opcodes, flush NOP word,
// sequencing-controller state encoding and register-dependency helpers.
package pipe_pkg;

  localparam logic [5:0]  OP_RTYPE   = 6'd0;
  localparam logic [5:0]  OP_J       = 6'd2;
  localparam logic [5:0]  OP_BEQ     = 6'd4;
  localparam logic [5:0]  OP_LW      = 6'd35;
  localparam logic [5:0]  OP_SW      = 6'd43;

  // Word loaded into IF/ID when it is flushed.
  localparam logic [31:0] INST_FLUSH = 32'hFC00_0000;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    WAIT  = 2'd1,
    ERROR = 2'd2
  } state_e;

  // Instructions that read the rt field as a source operand.
  function automatic logic uses_rt(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_BEQ) || (op == OP_SW);
  endfunction

  // A producer register r feeds the ID instruction. $zero never creates a
  // dependency because it is hard-wired.
  function automatic logic reg_match(input logic [4:0] r,
                                     input logic [4:0] rs,
                                     input logic [4:0] rt,
                                     input logic       rt_used);
    return (r != 5'd0) && ((r == rs) || (rt_used && (r == rt)));
  endfunction

endpackage

// File: rtl/hazard_detect.sv
// Combinational hazard detection for the instruction held in IF/ID.
// Ports:
//   id_op_i/id_rs_i/id_rt_i          IF/ID opcode and source fields
//   ex_regwrite_i/ex_memread_i/ex_rd_i  ID/EX producer information
//   mem_memread_i/mem_rd_i           EX/MEM load producer
//   load_use_o                       ID consumer depends on a load in EX
//   br_haz_o                         beq operand not yet available in ID
module hazard_detect
  import pipe_pkg::*;
(
  input  logic [5:0] id_op_i,
  input  logic [4:0] id_rs_i,
  input  logic [4:0] id_rt_i,
  input  logic       ex_regwrite_i,
  input  logic       ex_memread_i,
  input  logic [4:0] ex_rd_i,
  input  logic       mem_memread_i,
  input  logic [4:0] mem_rd_i,
  output logic       load_use_o,
  output logic       br_haz_o
);

  logic rt_used_s;
  logic ex_match_s;
  logic mem_match_s;

  assign rt_used_s   = uses_rt(id_op_i);
  assign ex_match_s  = reg_match(ex_rd_i, id_rs_i, id_rt_i, rt_used_s);
  assign mem_match_s = reg_match(mem_rd_i, id_rs_i, id_rt_i, rt_used_s);

  assign load_use_o  = ex_memread_i && ex_match_s;
  // beq compares in ID, so it must wait for ALU results in EX and for load
  // data that is still in MEM.
  assign br_haz_o    = (id_op_i == OP_BEQ) &&
                       ((ex_regwrite_i && ex_match_s) ||
                        (mem_memread_i && mem_match_s));

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller: PC write enable, IF/ID hold/flush, ID/EX
// bubble, global freeze on memory waits with timeout, stall-cycle counter.
// Ports:
//   clk_i, rst_i                     clock, synchronous active-high reset
//   id_*/ex_*/mem_*                  pipeline register fields for hazards
//   branch_taken_i, jump_i           control transfer resolved in ID
//   imem_ready_i, dmem_ready_i       memories complete this cycle
//   pc_write_o, ifid_hold_o, ifid_flush_o, idex_bubble_o, pipe_freeze_o
//                                    Mealy sequencing controls
//   mem_err_o                        sticky memory timeout flag
//   stall_cnt_o                      saturating count of PC-hold cycles
module hazard_ctrl #(
  parameter int unsigned TIMEOUT     = 255,
  parameter int unsigned STALL_CNT_W = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [5:0]             id_op_i,
  input  logic [4:0]             id_rs_i,
  input  logic [4:0]             id_rt_i,
  input  logic                   ex_regwrite_i,
  input  logic                   ex_memread_i,
  input  logic [4:0]             ex_rd_i,
  input  logic                   mem_memread_i,
  input  logic [4:0]             mem_rd_i,
  input  logic                   branch_taken_i,
  input  logic                   jump_i,
  input  logic                   imem_ready_i,
  input  logic                   dmem_ready_i,
  output logic                   pc_write_o,
  output logic                   ifid_hold_o,
  output logic                   ifid_flush_o,
  output logic                   idex_bubble_o,
  output logic                   pipe_freeze_o,
  output logic                   mem_err_o,
  output logic [STALL_CNT_W-1:0] stall_cnt_o
);

  import pipe_pkg::*;

  localparam logic [7:0]             TIMEOUT_C = 8'(TIMEOUT);
  localparam logic [STALL_CNT_W-1:0] CNT_ONE   = STALL_CNT_W'(1);
  localparam logic [STALL_CNT_W-1:0] CNT_MAX   = {STALL_CNT_W{1'b1}};

  state_e                   state_q, state_d;
  logic [7:0]               wait_cnt_q, wait_cnt_d;
  logic [STALL_CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
  logic                     err_q, err_d;

  logic load_use_s;
  logic br_haz_s;
  logic hazard_s;
  logic mem_busy_s;

  // Controls for an unfrozen cycle (RUN, or WAIT once memory is ready).
  logic run_pc_write_s;
  logic run_hold_s;
  logic run_flush_s;
  logic run_bubble_s;

  hazard_detect u_detect (
    .id_op_i       (id_op_i),
    .id_rs_i       (id_rs_i),
    .id_rt_i       (id_rt_i),
    .ex_regwrite_i (ex_regwrite_i),
    .ex_memread_i  (ex_memread_i),
    .ex_rd_i       (ex_rd_i),
    .mem_memread_i (mem_memread_i),
    .mem_rd_i      (mem_rd_i),
    .load_use_o    (load_use_s),
    .br_haz_o      (br_haz_s)
  );

  assign hazard_s   = load_use_s || br_haz_s;
  assign mem_busy_s = !imem_ready_i || !dmem_ready_i;

  // Unfrozen-cycle controls: a hazard stall suppresses the flush because the
  // branch decision was made on stale operands.
  always_comb begin
    run_pc_write_s = 1'b1;
    run_hold_s     = 1'b0;
    run_flush_s    = 1'b0;
    run_bubble_s   = 1'b0;
    if (hazard_s) begin
      run_pc_write_s = 1'b0;
      run_hold_s     = 1'b1;
      run_bubble_s   = 1'b1;
    end else if (branch_taken_i || jump_i) begin
      run_flush_s    = 1'b1;
    end else begin
      run_pc_write_s = 1'b1;
    end
  end

  // FSM next state, wait counter and Mealy outputs.
  always_comb begin
    state_d       = state_q;
    wait_cnt_d    = wait_cnt_q;
    pc_write_o    = 1'b0;
    ifid_hold_o   = 1'b0;
    ifid_flush_o  = 1'b0;
    idex_bubble_o = 1'b0;
    pipe_freeze_o = 1'b0;
    if (rst_i) begin
      // IF/ID has no reset of its own; load the flush NOP into it now.
      ifid_flush_o  = 1'b1;
      idex_bubble_o = 1'b1;
      state_d       = RUN;
      wait_cnt_d    = 8'd0;
    end else begin
      case (state_q)
        RUN: begin
          if (mem_busy_s) begin
            ifid_hold_o   = 1'b1;
            pipe_freeze_o = 1'b1;
            state_d       = WAIT;
            wait_cnt_d    = 8'd1;
          end else begin
            pc_write_o    = run_pc_write_s;
            ifid_hold_o   = run_hold_s;
            ifid_flush_o  = run_flush_s;
            idex_bubble_o = run_bubble_s;
          end
        end
        WAIT: begin
          if (mem_busy_s) begin
            ifid_hold_o   = 1'b1;
            pipe_freeze_o = 1'b1;
            if (wait_cnt_q == TIMEOUT_C) begin
              state_d = ERROR;
            end else begin
              wait_cnt_d = wait_cnt_q + 8'd1;
            end
          end else begin
            // First ready cycle completes the instruction immediately.
            pc_write_o    = run_pc_write_s;
            ifid_hold_o   = run_hold_s;
            ifid_flush_o  = run_flush_s;
            idex_bubble_o = run_bubble_s;
            state_d       = RUN;
            wait_cnt_d    = 8'd0;
          end
        end
        ERROR: begin
          ifid_hold_o   = 1'b1;
          pipe_freeze_o = 1'b1;
        end
        default: begin
          // Unreachable encoding: freeze and recover into ERROR visibly.
          ifid_hold_o   = 1'b1;
          pipe_freeze_o = 1'b1;
          state_d       = ERROR;
        end
      endcase
    end
  end

  // Sticky error flag and saturating stall counter (frozen once in ERROR).
  always_comb begin
    err_d       = err_q || (state_d == ERROR);
    stall_cnt_d = stall_cnt_q;
    if ((state_q != ERROR) && !pc_write_o && (stall_cnt_q != CNT_MAX)) begin
      stall_cnt_d = stall_cnt_q + CNT_ONE;
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
  end

  // State and counter registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= RUN;
      wait_cnt_q  <= 8'd0;
      stall_cnt_q <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      err_q       <= err_d;
    end
  end

  assign mem_err_o   = err_q;
  assign stall_cnt_o = stall_cnt_q;

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline sequencing controller for the five-stage core. It drives the PC write enable, the IF/ID hold (`hd_i`) and flush (`flush_i`) controls, and the ID/EX bubble insert. It also generates a global freeze while instruction or data memory is not ready. It detects load-use and branch-operand hazards, squashes wrong-path fetches after taken branches and jumps, watches memory waits with a timeout, and counts stall cycles.

## Interface
- `TIMEOUT`, default 255: maximum consecutive memory-wait cycles before the error state; wait counter is 8 bits wide.
- `STALL_CNT_W`, default 16: width of the stall-cycle counter.

- `clk_i`  in  1  single clock, all state updates on rising edge.
- `rst_i`  in  1  reset, synchronous and active-high.
- `id_op_i`  in  6  opcode of the instruction held in IF/ID.
- `id_rs_i`, `id_rt_i`  in  5 each  source fields of the IF/ID instruction.
- `ex_regwrite_i`, `ex_memread_i`  in  1 each  ID/EX control bits.
- `ex_rd_i`  in  5  ID/EX destination register, after the RegDst mux.
- `mem_memread_i`  in  1  EX/MEM load flag.
- `mem_rd_i`  in  5  EX/MEM destination register.
- `branch_taken_i`  in  1  beq in ID resolved taken.
- `jump_i`  in  1  j in ID.
- `imem_ready_i`, `dmem_ready_i`  in  1 each  memory completes this cycle.
- `pc_write_o`  out  1  PC load enable.
- `ifid_hold_o`  out  1  to IF/ID `hd_i`; 1 = keep contents.
- `ifid_flush_o`  out  1  to IF/ID `flush_i`; loads the flush NOP.
- `idex_bubble_o`  out  1  zero ID/EX control bits on the next edge.
- `pipe_freeze_o`  out  1  hold ID/EX, EX/MEM and MEM/WB.
- `mem_err_o`  out  1  sticky memory timeout flag.
- `stall_cnt_o`  out  `STALL_CNT_W`  saturating count of cycles with `pc_write_o`=0.

## Operation
- FSM state, wait counter, stall counter and error flag are registered. Outputs are combinational (Mealy) from the current state and inputs.
- `uses_rt` = `id_op_i` ∈ {R-type 0, beq 4, sw 43}.
- `match(r)`: r≠0 and (r==`id_rs_i` or (`uses_rt` and r==`id_rt_i`)).
- `load_use`: `ex_memread_i` and `match(ex_rd_i)`.
- `br_haz`: `id_op_i`==beq and ((`ex_regwrite_i` and `match(ex_rd_i)`) or (`mem_memread_i` and `match(mem_rd_i)`)).
- `hazard` = `load_use` or `br_haz`.
- `mem_busy` = not `imem_ready_i` or not `dmem_ready_i`.
- Priority: reset > ERROR > `mem_busy` > `hazard` > flush.
- Reset cycle (`rst_i`=1): `pc_write_o`=0, `ifid_flush_o`=1, `idex_bubble_o`=1, `ifid_hold_o`=0, `pipe_freeze_o`=0. The IF/ID register has no reset, so this cycle initialises it to the NOP. On the next edge: state RUN, counters 0, `mem_err_o`=0.
- State RUN:
  - If `mem_busy`: freeze, i.e. `pc_write_o`=0, `ifid_hold_o`=1, `pipe_freeze_o`=1, no bubble, no flush. Next state WAIT, wait counter ← 1.
  - Else if `hazard`: `pc_write_o`=0, `ifid_hold_o`=1, `idex_bubble_o`=1. Flush is suppressed because the branch result is stale.
  - Else if `branch_taken_i` or `jump_i`: `ifid_flush_o`=1, `pc_write_o`=1.
  - Else: `pc_write_o`=1, all other controls 0.
- State WAIT:
  - Freeze outputs are asserted while `mem_busy`; the wait counter increments.
  - When `mem_busy`=0: evaluate exactly as RUN in the same cycle, and next state is RUN.
  - If the counter equals `TIMEOUT` while still busy: next state ERROR, `mem_err_o` ← 1.
- State ERROR: freeze outputs are held permanently. `mem_err_o`=1 and the stall counter stops. Only reset leaves this state.
- Stall counter: increments on each non-reset cycle with `pc_write_o`=0 outside ERROR. It saturates at all-ones.

## Timing
- Zero-cycle control latency: hazard, flush and freeze affect the same rising edge at which the condition is present.
- Load-use costs 1 stall cycle. A beq dependent on an ALU op costs 1 cycle. A beq dependent on a load costs 2 cycles (EX then MEM match).
- Taken branch or jump costs 1 flushed slot.
- A memory wait of N cycles freezes for exactly N cycles. The instruction completes on the first ready cycle.
- `mem_err_o` rises on the edge after the `TIMEOUT`-th busy cycle in WAIT.
- Reset mid-WAIT or mid-ERROR returns to RUN on the next edge, with the counters cleared.

## Structure
- Shared package `pipe_pkg`:
  - opcodes `OP_RTYPE`=0, `OP_J`=2, `OP_BEQ`=4, `OP_LW`=35, `OP_SW`=43;
  - flush NOP word `INST_FLUSH`=32'hFC000000;
  - state enum {RUN, WAIT, ERROR}.
- One natural sub-module, `hazard_detect`: combinational computation of `load_use`/`br_haz`. The FSM and counters stay in `hazard_ctrl`.

## Test plan
- Reset: hold `rst_i` 1 cycle → `ifid_flush_o`=1, `pc_write_o`=0. Afterwards `stall_cnt_o`=0, `mem_err_o`=0.
- lw $2 in EX (`ex_memread_i`=1, `ex_rd_i`=2), add with rs=2 in ID → 1 cycle of `pc_write_o`=0, `ifid_hold_o`=1, `idex_bubble_o`=1. Then normal operation; `stall_cnt_o`=1.
- beq rs=3 following lw $3 → 2 stall cycles (EX match, then MEM match). While `branch_taken_i`=1 in those cycles, `ifid_flush_o` stays 0. It rises on the 3rd cycle.
- `jump_i`=1 with no hazard → `ifid_flush_o`=1, `pc_write_o`=1 for exactly 1 cycle.
- `dmem_ready_i`=0 for 5 cycles with a load-use present → `pipe_freeze_o`=1 for 5 cycles with no bubble. The bubble appears on the 6th cycle.
- `TIMEOUT`=4, `imem_ready_i` held 0 → `mem_err_o` rises after the 4th WAIT cycle and stays with freeze held. Reset clears it.
